piso_stream: RTL and testbench



---
 rtl/piso_pkg.sv | 26 ++
 rtl/piso_bit_counter.sv | 44 ++++
 rtl/piso_stream.sv | 132 +++++++++++++
 tb/tb_piso_stream.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// ============================================================================
// Module : piso_pkg
// Brief  : Shared types and constants for the piso_stream serialiser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic ORDER_MSB = 1'b0;
  localparam logic ORDER_LSB = 1'b1;

  // Counter must reach WIDTH when the parity bit is appended.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_bit_counter.sv
// ============================================================================
// Module : piso_bit_counter
// Brief  : Frame bit counter with clear/increment and first/last decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module piso_bit_counter #(
  parameter int CNT_W     = 4,
  parameter int LAST      = 7,
  parameter int DATA_LAST = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_active,
  output logic o_first,
  output logic o_last,
  output logic o_data_last
);

  localparam logic [CNT_W-1:0] c_LAST      = CNT_W'(LAST);
  localparam logic [CNT_W-1:0] c_DATA_LAST = CNT_W'(DATA_LAST);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_first     = i_active && (r_cnt == '0);
  assign o_last      = i_active && (r_cnt == c_LAST);
  assign o_data_last = i_active && (r_cnt == c_DATA_LAST);

endmodule

`default_nettype wire

// File: rtl/piso_stream.sv
// ============================================================================
// Module : piso_stream
// Brief  : Parallel-in/serial-out shifter with valid/ready input, one-word
//          holding buffer and gap-free back-to-back framing.
//          Build option: PISO_PARITY_EN appends an even-parity bit per frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module piso_stream import piso_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_first,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             out_valid,
  output logic             frame_first,
  output logic             frame_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int c_LAST = WIDTH;
`else
  localparam int c_LAST = WIDTH - 1;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic             r_lsb;
  logic [WIDTH-1:0] r_hold_data;
  logic             r_hold_lsb;
  logic             r_hold_full;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

  logic w_accept;
  logic w_frame_end;
  logic w_load;
  logic w_data_last;

  assign in_ready  = !r_hold_full && !reset;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state != ST_IDLE);
  assign busy      = out_valid || r_hold_full;

`ifdef PISO_PARITY_EN
  assign w_frame_end = shift_en && (r_state == ST_PARITY);
`else
  assign w_frame_end = shift_en && w_data_last;
`endif
  // Reload straight from the buffer at frame end so no idle bit appears.
  assign w_load = r_hold_full && ((r_state == ST_IDLE) || w_frame_end);

  piso_bit_counter #(
    .CNT_W     (CNT_W),
    .LAST      (c_LAST),
    .DATA_LAST (WIDTH - 1)
  ) u_bit_counter (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_load || w_frame_end),
    .i_inc       (shift_en && out_valid),
    .i_active    (out_valid),
    .o_first     (frame_first),
    .o_last      (frame_last),
    .o_data_last (w_data_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_lsb       <= ORDER_MSB;
      r_hold_data <= '0;
      r_hold_lsb  <= ORDER_MSB;
      r_hold_full <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_hold_data <= in_data;
        r_hold_lsb  <= in_lsb_first;
      end
      r_hold_full <= w_accept || (r_hold_full && !w_load);

      if (w_load) begin
        r_sr    <= r_hold_data;
        r_lsb   <= r_hold_lsb;
        r_state <= ST_SHIFT;
`ifdef PISO_PARITY_EN
        r_par   <= ^r_hold_data;
`endif
      end else if (w_frame_end) begin
        r_state <= ST_IDLE;
      end else if (shift_en) begin
        case (r_state)
          ST_SHIFT: begin
            r_sr <= (r_lsb == ORDER_LSB) ? {1'b0, r_sr[WIDTH-1:1]}
                                         : {r_sr[WIDTH-2:0], 1'b0};
`ifdef PISO_PARITY_EN
            if (w_data_last) r_state <= ST_PARITY;
`endif
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  always_comb begin
    serial_out = 1'b0;
    case (r_state)
      ST_SHIFT:  serial_out = (r_lsb == ORDER_MSB) ? r_sr[WIDTH-1] : r_sr[0];
`ifdef PISO_PARITY_EN
      ST_PARITY: serial_out = r_par;
`endif
      default:   serial_out = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_stream.sv
// ============================================================================
// Module : tb_piso_stream
// Brief  : Self-checking bench for piso_stream (WIDTH=4), frame-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_piso_stream;

  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_lsb_first;
  logic             shift_en;
  logic             serial_out;
  logic             out_valid;
  logic             frame_first;
  logic             frame_last;
  logic             busy;

  always #5 clk = ~clk;

  piso_stream #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_lsb_first (in_lsb_first),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .out_valid    (out_valid),
    .frame_first  (frame_first),
    .frame_last   (frame_last),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a frame is a list of bits with a read position, plus a 1-deep buffer.
  bit               m_active;
  bit               m_buf_full;
  logic [WIDTH-1:0] m_buf_data;
  bit               m_buf_lsb;
  bit               m_bits[FL];
  int               m_pos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_start(input logic [WIDTH-1:0] w, input bit lsb);
    for (int i = 0; i < WIDTH; i++) m_bits[i] = lsb ? w[i] : w[WIDTH-1-i];
`ifdef PISO_PARITY_EN
    m_bits[FL-1] = ^w;
`endif
    m_active = 1'b1;
    m_pos    = 0;
  endfunction

  task automatic step();
    bit r, v, l, s, acc, used;
    logic [WIDTH-1:0] d;
    logic [5:0] exp_v;
    r = reset; v = in_valid; d = in_data; l = in_lsb_first; s = shift_en;
    @(posedge clk);
    if (r) begin
      m_active = 0; m_buf_full = 0; m_pos = 0;
    end else begin
      acc  = v && !m_buf_full;
      used = 0;
      if (!m_active) begin
        if (m_buf_full) begin m_start(m_buf_data, m_buf_lsb); used = 1; end
      end else if (s) begin
        if (m_pos == FL - 1) begin
          if (m_buf_full) begin m_start(m_buf_data, m_buf_lsb); used = 1; end
          else m_active = 0;
        end else begin
          m_pos++;
        end
      end
      if (acc) begin m_buf_full = 1; m_buf_data = d; m_buf_lsb = l; end
      else if (used) m_buf_full = 0;
    end
    #1;
    exp_v = {!m_buf_full && !reset, m_active, m_active ? m_bits[m_pos] : 1'b0,
             m_active && m_pos == 0, m_active && m_pos == FL - 1, m_active || m_buf_full};
    check("model", {in_ready, out_valid, serial_out, frame_first, frame_last, busy}, exp_v);
  endtask

  typedef struct {
    logic [WIDTH-1:0] word;
    bit               lsb;
    logic [WIDTH-1:0] seq;   // emitted order, first bit at the MSB
    bit               par;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [3:0]      smp[2*FL];
    logic [2*FL-1:0] b2b_seq;
    logic [FL-1:0]   tog_seq;
    bit              exp_bit;
    int              nv;

    vecs[0] = '{4'b1011, 1'b0, 4'b1011, 1'b1};
    vecs[1] = '{4'b1011, 1'b1, 4'b1101, 1'b1};
    vecs[2] = '{4'b1100, 1'b0, 4'b1100, 1'b0};
    vecs[3] = '{4'b0001, 1'b1, 4'b1000, 1'b1};
    vecs[4] = '{4'b1110, 1'b1, 4'b0111, 1'b1};
    vecs[5] = '{4'b0110, 1'b0, 4'b0110, 1'b0};
`ifdef PISO_PARITY_EN
    b2b_seq = 10'b10100_00110;
    tog_seq = 5'b11000;
`else
    b2b_seq = 8'b1010_0011;
    tog_seq = 4'b1100;
`endif

    // Reset: input offered but never taken while reset is high
    reset = 1; in_valid = 1; in_data = 4'h9; in_lsb_first = 0; shift_en = 1;
    step(); step();
    check("reset_state", {in_ready, out_valid, busy, serial_out, frame_first, frame_last}, 6'b0);
    reset = 0; in_valid = 0;
    step();
    check("post_reset_idle", {out_valid, busy}, 2'b00);

    // Single words from the table, shift_en held high
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_data = vecs[k].word; in_lsb_first = vecs[k].lsb; shift_en = 1;
      step();
      in_valid = 0;
      step();
      for (int i = 0; i < FL; i++) begin
        exp_bit = (i < WIDTH) ? vecs[k].seq[WIDTH-1-i] : vecs[k].par;
        check("tbl_bit", {out_valid, serial_out, frame_first, frame_last},
              {1'b1, exp_bit, i == 0, i == FL - 1});
        step();
      end
      check("tbl_end", {out_valid, busy}, 2'b00);
    end

    // Back-to-back words: buffer full stalls the producer, no gap bit
    in_valid = 1; in_data = 4'hA; in_lsb_first = 0; shift_en = 1;
    step();
    check("b2b_ready_low", in_ready, 1'b0);
    in_data = 4'h3;
    step();
    for (int i = 0; i < 2*FL; i++) begin
      smp[i] = {out_valid, serial_out, frame_first, frame_last};
      step();
      if (i == 0) in_valid = 0;
    end
    for (int i = 0; i < 2*FL; i++)
      check("b2b_bit", smp[i], {1'b1, b2b_seq[2*FL-1-i], (i % FL) == 0, (i % FL) == FL - 1});
    check("b2b_end", {out_valid, busy}, 2'b00);

    // Strobed shifting: every bit held for two cycles
    in_valid = 1; in_data = 4'b1100; in_lsb_first = 0; shift_en = 1;
    step();
    in_valid = 0;
    step();
    nv = 0;
    for (int j = 0; j < 2*FL + 2; j++) begin
      shift_en = (j % 2 == 1);
      if (out_valid) nv++;
      if (j < 2*FL) check("tog_bit", serial_out, tog_seq[FL-1-j/2]);
      step();
    end
    check("tog_valid_cycles", nv, 2*FL);
    shift_en = 1;

    // Reset during bit 2 with a second word buffered
    in_valid = 1; in_data = 4'hF; in_lsb_first = 0;
    step();
    in_data = 4'h5;
    step();
    step();
    in_valid = 0;
    step();
    check("rst_mid_frame_bit2", {out_valid, busy, frame_first}, 3'b110);
    reset = 1;
    step();
    reset = 0;
    #1;
    check("rst_outputs", {out_valid, busy, in_ready, serial_out, frame_first, frame_last}, 6'b001000);
    nv = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (out_valid) nv++;
    end
    check("rst_buffer_dropped", nv, 0);

    // Randomised traffic against the frame-level model
    for (int c = 0; c < 600; c++) begin
      in_valid     = 1'($urandom_range(0, 1));
      in_data      = WIDTH'($urandom);
      in_lsb_first = 1'($urandom_range(0, 1));
      shift_en     = ($urandom_range(0, 3) != 0);
      reset        = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
